main_memory_timed: RTL and testbench

Parametrised, clocked successor to the combinational main-memory models: one storage array of cache blocks serving both cache policies. Block reads feed cache refills. Block writes serve write-back evictions. Single-word writes serve write-through stores. Every request pays a configurable access latency behind a valid/ready handshake, so the cache controller can be exercised against realistic miss penalties.

---
 rtl/main_memory_timed.sv | 142 ++++++++++++++
 tb/tb_main_memory_timed.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_timed.sv
`default_nettype none
// ============================================================================
// Module      : main_memory_timed
// Description : Block-organised main memory with a fixed access latency behind
//               a valid/ready handshake (block read, block write, word write).
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory_timed #(
  parameter int ADDR_W  = 10,
  parameter int WORD_W  = 32,
  parameter int WPB     = 4,
  parameter int LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_block,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [WPB*WORD_W-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [WPB*WORD_W-1:0]   resp_rdata
);

  localparam int c_OFF   = $clog2(WPB);
  localparam int c_BLK_W = ADDR_W - c_OFF;
  localparam int c_DEPTH = 1 << c_BLK_W;
  localparam int c_BW    = WPB * WORD_W;
  localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_ready;
  logic                r_resp_valid;
  logic [c_BW-1:0]     r_resp_rdata;
  logic                r_write;
  logic                r_block;
  logic [ADDR_W-1:0]   r_addr;
  logic [c_BW-1:0]     r_wdata;
  logic [c_BW-1:0]     r_mem [c_DEPTH];

  logic                w_accept;
  logic                w_direct;
  logic                w_wait_done;
  logic                w_commit;
  logic                w_c_write;
  logic                w_c_block;
  logic [ADDR_W-1:0]   w_c_addr;
  logic [c_BW-1:0]     w_c_wdata;
  logic [c_BLK_W-1:0]  w_c_blk;
  logic [c_OFF-1:0]    w_c_off;

  assign w_accept    = req_valid && r_ready;
  // With a single-cycle latency the commit happens on the accept edge itself,
  // so the request fields come straight from the ports instead of the capture regs.
  assign w_direct    = w_accept && (LATENCY == 1);
  assign w_wait_done = (r_state == S_WAIT) && (r_cnt == c_CNT_ONE);
  assign w_commit    = w_direct || w_wait_done;

  assign w_c_write   = w_direct ? req_write : r_write;
  assign w_c_block   = w_direct ? req_block : r_block;
  assign w_c_addr    = w_direct ? req_addr  : r_addr;
  assign w_c_wdata   = w_direct ? req_wdata : r_wdata;
  assign w_c_blk     = w_c_addr[ADDR_W-1:c_OFF];
  assign w_c_off     = w_c_addr[c_OFF-1:0];

  // Storage array: no reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_c_write) begin
      for (int k = 0; k < WPB; k++) begin
        if (w_c_block || (int'(w_c_off) == k)) begin
          r_mem[w_c_blk][k*WORD_W +: WORD_W] <= w_c_block ?
              w_c_wdata[k*WORD_W +: WORD_W] : w_c_wdata[WORD_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_write      <= 1'b0;
      r_block      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_commit && !w_c_write) begin
        r_resp_rdata <= r_mem[w_c_blk];
      end
      case (r_state)
        S_WAIT: begin
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_ready      <= 1'b1;
          end
        end
        default: begin
          if (w_accept) begin
            r_write <= req_write;
            r_block <= req_block;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= c_CNT_LOAD;
            if (LATENCY > 1) begin
              r_state <= S_WAIT;
              r_ready <= 1'b0;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_ready      <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_main_memory_timed.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory_timed
// Description : Scoreboard bench for main_memory_timed (LATENCY 4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory_timed;

  localparam int AW  = 10;
  localparam int WW  = 32;
  localparam int WPB = 4;
  localparam int BW  = WPB * WW;

  localparam logic [BW-1:0] P1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [BW-1:0] PW = 128'h44444444_33333333_22222222_11111111;
  localparam logic [BW-1:0] PX = 128'h44444444_33333333_12345678_11111111;
  localparam logic [BW-1:0] P2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [BW-1:0] P3 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [BW-1:0] P4 = 128'h99999999_99999999_99999999_99999999;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sel = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic          req_block = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [BW-1:0] req_wdata = '0;
  logic          v4, v1, rdy4, rdy1, rv4, rv1;
  logic [BW-1:0] rd4, rd1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            is_read;
    logic [BW-1:0] data;
    int            edge_n;
  } exp_t;
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;

  assign v4 = req_valid && !sel;
  assign v1 = req_valid && sel;

  main_memory_timed #(.ADDR_W(AW), .WORD_W(WW), .WPB(WPB), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(v4), .req_ready(rdy4),
    .req_write(req_write), .req_block(req_block), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv4), .resp_rdata(rd4)
  );

  main_memory_timed #(.ADDR_W(AW), .WORD_W(WW), .WPB(WPB), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1),
    .req_write(req_write), .req_block(req_block), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: pop one expectation per response pulse.
  always @(negedge clk) begin
    if (rv4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut4_unexpected_resp: actual=pulse required=none (cycle %0d)", cyc);
      end else begin
        e4 = q4.pop_front();
        chk("dut4_resp_edge", BW'(cyc), BW'(e4.edge_n));
        if (e4.is_read) chk("dut4_rdata", rd4, e4.data);
      end
    end
  end

  always @(negedge clk) begin
    if (rv1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_unexpected_resp: actual=pulse required=none (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_resp_edge", BW'(cyc), BW'(e1.edge_n));
        if (e1.is_read) chk("dut1_rdata", rd1, e1.data);
      end
    end
  end

  task automatic issue(input bit s, input bit w, input bit b, input logic [AW-1:0] a,
                       input logic [BW-1:0] d, input logic [BW-1:0] ex, input bit expect_resp,
                       output int acc, output int stalls);
    exp_t e;
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_write = w; req_block = b; req_addr = a; req_wdata = d;
    stalls = 0;
    acc = -1;
    while (!(s ? rdy1 : rdy4)) begin
      if (stalls >= 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: actual=ready low %0d cycles required=accept", stalls);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      stalls++;
    end
    acc = cyc + 1;
    if (expect_resp) begin
      e.is_read = !w;
      e.data    = ex;
      e.edge_n  = acc + (s ? 1 : 4) - 1;
      if (s) q1.push_back(e);
      else   q4.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while ((q4.size() != 0 || q1.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", BW'(q4.size() + q1.size()), '0);
    @(negedge clk);
  endtask

  initial begin
    int a0, a1, a2, a3, s0, s1, s2, s3;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state held while idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_ready4", BW'(rdy4), BW'(1));
      chk("rst_valid4", BW'(rv4), '0);
      chk("rst_rdata4", rd4, '0);
      chk("rst_valid1", BW'(rv1), '0);
    end

    // Block write then read of the same block, back-to-back
    issue(0, 1, 1, 10'h3F4, P1, '0, 1, a0, s0);
    issue(0, 0, 0, 10'h3F6, '0, P1, 1, a1, s1);
    chk("raw_accept_gap", BW'(a1 - a0), BW'(4));
    drain();

    // Word write into lane 1 of a preloaded block; upper wdata bits must be ignored
    issue(0, 1, 1, 10'h008, PW, '0, 1, a0, s0);
    issue(0, 1, 0, 10'h009, {96'hFFFFFFFF_EEEEEEEE_DDDDDDDD, 32'h12345678}, '0, 1, a1, s1);
    issue(0, 0, 0, 10'h008, '0, PX, 1, a2, s2);
    drain();

    // Three back-to-back reads with valid held high
    issue(0, 0, 0, 10'h3F4, '0, P1, 1, a0, s0);
    issue(0, 0, 0, 10'h008, '0, PX, 1, a1, s1);
    issue(0, 0, 1, 10'h3F7, '0, P1, 1, a2, s2);
    chk("b2b_gap1", BW'(a1 - a0), BW'(4));
    chk("b2b_gap2", BW'(a2 - a1), BW'(4));
    chk("b2b_stall1", BW'(s1), BW'(3));
    chk("b2b_stall2", BW'(s2), BW'(3));
    drain();

    // LATENCY=1 instance: accept on every edge, response every cycle
    issue(1, 1, 1, 10'h010, P2, '0, 1, a0, s0);
    issue(1, 0, 0, 10'h010, '0, P2, 1, a1, s1);
    issue(1, 0, 0, 10'h011, '0, P2, 1, a2, s2);
    issue(1, 0, 0, 10'h013, '0, P2, 1, a3, s3);
    chk("l1_gap1", BW'(a1 - a0), BW'(1));
    chk("l1_gap2", BW'(a2 - a1), BW'(1));
    chk("l1_gap3", BW'(a3 - a2), BW'(1));
    chk("l1_stalls", BW'(s1 + s2 + s3), '0);
    drain();

    // Reset during the second WAIT cycle aborts a block write
    issue(0, 1, 1, 10'h100, P3, '0, 1, a0, s0);
    drain();
    issue(0, 1, 1, 10'h100, P4, '0, 0, a1, s1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rdata_reset", rd4, '0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_valid", BW'(rv4), '0);
      chk("abort_ready", BW'(rdy4), BW'(1));
      @(negedge clk);
    end
    issue(0, 0, 0, 10'h100, '0, P3, 1, a2, s2);
    drain();

    // Inputs wiggling while not ready must not be accepted
    issue(0, 0, 0, 10'h3F4, '0, P1, 1, a0, s0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = (i != 1);
      req_write = 1'b1;
      req_block = 1'b1;
      req_addr  = 10'h3F4 ^ AW'(i);
      req_wdata = {4{32'hBAD0_0000 | 32'(i)}};
    end
    drain();
    issue(0, 0, 0, 10'h3F5, '0, P1, 1, a1, s1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
